mul_sequencer: RTL and testbench

Multi-cycle controller that sequences the integer multiply for the ALU `MUL` operation code 4'b1001. It uses an iterative shift-add datapath and holds the pipeline with a stall request until the product is ready. It sits beside the single-cycle ALU in the execute stage, monitors the decoded `alu_control`, and captures the operands when a `MUL` is issued. It returns the low `XLEN` bits of the product, which matches RV32M `MUL` semantics.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/mul_shift_add_dp.sv | 40 ++++
 rtl/mul_sequencer.sv | 83 ++++++++
 tb/tb_mul_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, machine width and the
// multiply sequencer state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Iterative shift-add multiply datapath: multiplicand, multiplier and
// accumulator registers with load/step controls. acc holds the low XLEN bits.
module mul_shift_add_dp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] acc,
  output logic            mplier_zero
);

  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load) begin
      mcand_q  <= op_a;
      mplier_q <= op_b;
      acc_q    <= '0;
    end else if (step) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // Looks one step ahead: true when the multiplier is zero after this step's shift.
  assign mplier_zero = (mplier_q[XLEN-1:1] == '0);
  assign acc         = acc_q;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL controller: IDLE/BUSY/DONE FSM, iteration counter and
// pipeline stall/done logic. Define MUL_EARLY_OUT_EN to finish early.
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

`ifdef MUL_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic             accept, step, last_iter, mplier_zero;

  assign accept    = start & (alu_control == ALU_MUL) & (state_q == IDLE) & ~flush;
  assign step      = (state_q == BUSY) & ~flush;
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (EARLY_OUT && op_b == '0) ? DONE : BUSY;
      BUSY: begin
        if (flush)                                      state_d = IDLE;
        else if (last_iter || (EARLY_OUT && mplier_zero)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == BUSY);
      done_q  <= (state_d == DONE);
      if (accept)    cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + 1'b1;
    end
  end

  mul_shift_add_dp #(.XLEN(XLEN)) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept),
    .step        (step),
    .op_a        (op_a),
    .op_b        (op_b),
    .acc         (result),
    .mplier_zero (mplier_zero)
  );

  // Stall drops in DONE so the pipeline advances alongside the done pulse.
  assign stall     = busy_q | accept;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer; follows MUL_EARLY_OUT_EN if defined.
module tb_mul_sequencer;
  import cpu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   alu_control;
  logic [W-1:0] op_a, op_b;
  logic         flush;
  logic         stall, busy, done;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_result;
  int checks   = 0;
  int failures = 0;

  mul_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MUL_EARLY_OUT_EN
    int hi = -1;
    for (int i = 0; i < W; i++) if (b[i]) hi = i;
    return (hi < 0) ? 1 : hi + 2;
`else
    return W + 1;
`endif
  endfunction

  // Issue a MUL in the next cycle (cycle 0) and follow it to its done pulse.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_start);
    logic [W-1:0] prod;
    int lat, cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1; alu_control = ALU_MUL; op_a = a; op_b = b;
    #1;
    check("accept_stall", stall, 1);
    prod = a * b;
    exp_q.push_back(prod);
    lat  = exp_latency(b);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = 1'b0;
      #1;
      if (done) begin
        seen = 1'b1;
        check("done_cycle", cyc, lat);
        check("done_stall", stall, 0);
        check("done_busy", busy, 0);
        last_result = exp_q.pop_front();
        check("result", result, last_result);
      end else begin
        check("busy_run", busy, 1);
        check("stall_run", stall, 1);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; alu_control = ALU_ADD;
    op_a = '0; op_b = '0; flush = 1'b0; last_result = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_stall",  stall, 0);
    check("rst_result", result, 0);
    check("rst_state",  dbg_state, IDLE);
    rst_n = 1'b1;

    run_mul(32'd7, 32'd6, 1'b0);
    @(negedge clk); #1;
    check("post_done_busy",  busy, 0);
    check("post_done_state", dbg_state, IDLE);

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mul(32'h8000_0000, 32'd2, 1'b0);

    // Non-MUL code with start: nothing should move.
    @(negedge clk);
    start = 1'b1; alu_control = ALU_SLT; op_a = 32'd11; op_b = 32'd13;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("nomul_stall",  stall, 0);
      check("nomul_busy",   busy, 0);
      check("nomul_done",   done, 0);
      check("nomul_result", result, last_result);
    end
    start = 1'b0;

    // Flush in cycle 10 of an operation; new MUL in cycle 12.
    @(negedge clk);
    start = 1'b1; alu_control = ALU_MUL; op_a = 32'h1234_5678; op_b = 32'h8000_0001;
    #1 check("fl_accept_stall", stall, 1);
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk); flush = 1'b1;
    #1 check("fl_busy_c10", busy, 1);
    @(negedge clk); flush = 1'b0;
    #1;
    check("fl_state_c11", dbg_state, IDLE);
    check("fl_busy_c11",  busy, 0);
    check("fl_done_c11",  done, 0);
    run_mul(32'd3, 32'd3, 1'b0);

    run_mul(32'd5, 32'd3, 1'b0);
    run_mul(32'd9, 32'd0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_mul(ra, rb, 1'b0);
    end

    // Reset asserted in cycle 5 of a multiply.
    @(negedge clk);
    start = 1'b1; alu_control = ALU_MUL; op_a = 32'hDEAD_BEEF; op_b = 32'h8000_0003;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); #1;
    check("mrst_busy",   busy, 0);
    check("mrst_done",   done, 0);
    check("mrst_stall",  stall, 0);
    check("mrst_result", result, 0);
    check("mrst_state",  dbg_state, IDLE);
    rst_n = 1'b1; last_result = '0;

    // start held through BUSY/DONE must not restart the operation.
    run_mul(32'd21, 32'h8000_0002, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("held_busy", busy, 0);
      check("held_done", done, 0);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
